tdm_demux8: RTL
===============

Name: tdm_demux8

Overview:
- 1-to-8 demultiplexer; the inverse of the team's 8:1 selector.
- Distributes a single-bit stream onto an 8-bit registered output bus.
- Addressed mode: bits are steered by an explicit select.
- Sequenced mode: an internal slot counter assembles LSB-first 8-bit frames and flags each completed frame.
- Sits at the receive end of the serial channel that the 8:1 mux drives.

Parameters:
- N_CH, 8, number of output channels; must equal 2**SEL_W.
- SEL_W, 3, width of the channel select and slot counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- din  input  1  serial data bit.
- din_valid  input  1  din is sampled on this cycle's rising edge.
- sof  input  1  start-of-frame marker; qualified by din_valid; sequenced mode only.
- sel_mode  input  1  0 = addressed mode, 1 = sequenced mode.
- sel  input  SEL_W  destination channel in addressed mode.
- Y  output  N_CH  held channel outputs.
- frame  output  N_CH  last completed frame (sequenced mode).
- frame_valid  output  1  one-cycle pulse when frame updates.
- slot  output  SEL_W  next slot to be filled (sequenced mode).
- frame_err  output  1  one-cycle pulse on a premature sof.

Behaviour:
- Reset (rst=1 at a rising edge): Y=0, frame=0, frame_valid=0, frame_err=0, slot=0, shadow register=0, FSM=IDLE. Reset overrides all other inputs on that edge.
- All outputs are registered.
- frame_valid and frame_err are single-cycle pulses; each defaults to 0 on every cycle it is not set.
- Addressed mode (sel_mode=0):
  - On din_valid=1: Y[sel] <= din at the edge; all other Y bits hold.
  - Latency: 1 clock.
  - sof is ignored. FSM is held in IDLE, slot=0, shadow is cleared. frame, frame_valid and frame_err stay unchanged/0.
- Sequenced mode (sel_mode=1), FSM states IDLE and COLLECT:
  - IDLE: din_valid=1 with sof=1 -> shadow[0] <= din, slot <= 1, go to COLLECT. din_valid=1 with sof=0 -> bit is dropped, stay in IDLE, no error.
  - COLLECT, din_valid=1, sof=0, slot<N_CH-1: shadow[slot] <= din, slot <= slot+1.
  - COLLECT, din_valid=1, sof=0, slot=N_CH-1 (frame completion):
    - frame <= {din, shadow[N_CH-2:0]} and Y <= same value.
    - frame_valid=1 for the next cycle.
    - slot wraps to 0; go to IDLE.
    - frame_valid rises on the clock after the edge that sampled the 8th bit.
  - COLLECT, din_valid=1, sof=1 (premature sof):
    - frame_err=1 for one cycle; partial shadow is discarded.
    - shadow <= 0 with shadow[0] <= din; slot <= 1; stay in COLLECT.
    - frame and Y are not updated.
  - Back-to-back frames: a sof with the first bit of the next frame on the cycle immediately after a completion is accepted from IDLE, with no gap and no error.
  - din_valid=0: nothing changes; sof is ignored; the frame may be stretched indefinitely.
- Bit order: first bit received lands in bit 0, matching the mux index convention (channel k <-> bit k).
- Mode change 1->0 mid-frame: partial frame discarded, slot=0, IDLE, no frame_err; that cycle's din is handled by addressed-mode rules.
- Mode change 0->1: enters IDLE; the first frame needs a sof.
- Reset mid-frame: full reset values apply; the partial frame is lost and no pulses are emitted.

Test Plan:
- Reset check: assert rst for 2 cycles with random din/sof/sel -> Y=0x00, frame=0x00, slot=0, frame_valid=0, frame_err=0.
- Addressed mode: sel_mode=0; write din=1 to sel=0..7 in order, then din=0 to sel=3 -> Y steps 0x01, 0x03, ..., 0xFF, then 0xF7. frame_valid never asserts.
- Sequenced frame: sel_mode=1; bits 1,0,1,0,0,1,0,1 with sof on the first, din_valid gaps inserted -> one frame_valid pulse with frame=Y=0xA5, slot returns to 0.
- Back-to-back frames: two frames 0x3C then 0xC3 with no idle cycle -> two frame_valid pulses exactly 8 valid bits apart, frame=0x3C then 0xC3, frame_err=0.
- Premature sof: sof at bit 5 of a frame, followed by 8 bits of 0x81 -> frame_err pulse at the restart, frame=0x81, no frame_valid for the aborted frame.
- Abort paths: rst asserted after 4 bits, then (separately) sel_mode dropped after 4 bits -> slot=0, IDLE, no frame_valid; next sof frame of 0x5A completes correctly.

Source files
------------

// File: rtl/tdm_demux8.sv
// tdm_demux8: 1-to-8 demux of a serial bit stream; addressed (per-bit select) or sequenced (LSB-first frame assembly).
// Latency: 1 clock from the sampling edge to Y/frame/slot; frame_valid/frame_err pulse in the cycle after that edge.
// Backpressure: none; din_valid qualifies each bit and the block always accepts, so a frame may be stretched indefinitely.
module tdm_demux8 #(
  parameter int N_CH  = 8,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             sof,
  input  logic             sel_mode,
  input  logic [SEL_W-1:0] sel,
  output logic [N_CH-1:0]  Y,
  output logic [N_CH-1:0]  frame,
  output logic             frame_valid,
  output logic [SEL_W-1:0] slot,
  output logic             frame_err
);

  // Two-state frame collector; IDLE waits for sof, COLLECT fills slots 1..N_CH-1.
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_COLLECT = 1'b1;

  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(N_CH - 1);
  localparam logic [SEL_W-1:0] ONE_SLOT  = SEL_W'(1);

  // Registered state
  logic [0:0]       r_state;
  logic [SEL_W-1:0] r_slot;
  logic [N_CH-1:0]  r_shadow;
  logic [N_CH-1:0]  r_y;
  logic [N_CH-1:0]  r_frame;
  logic             r_frame_valid;
  logic             r_frame_err;

  // Decoded events for this cycle
  logic             w_seq_sof;
  logic             w_seq_bit;
  logic             w_done;
  logic             w_restart;
  logic [N_CH-1:0]  w_frame_dat;

  // Next-state values
  logic [0:0]       w_state_nxt;
  logic [SEL_W-1:0] w_slot_nxt;
  logic [N_CH-1:0]  w_shadow_nxt;
  logic [N_CH-1:0]  w_y_nxt;

  // Classify the sampled bit: a sof in sequenced mode always (re)starts a frame; a plain bit only counts while collecting.
  always_comb begin
    w_seq_sof = sel_mode & din_valid & sof;
    w_seq_bit = sel_mode & din_valid & ~sof & (r_state == ST_COLLECT);
    w_done    = w_seq_bit & (r_slot == LAST_SLOT);
    w_restart = w_seq_sof & (r_state == ST_COLLECT);
  end

  // Completed frame is the shadow with the final bit dropped into the top slot.
  always_comb begin
    w_frame_dat           = r_shadow;
    w_frame_dat[N_CH-1]   = din;
  end

  // Shadow register: cleared outside sequenced mode, reseeded on every sof, otherwise filled one slot per bit.
  always_comb begin
    w_shadow_nxt = r_shadow;
    if (!sel_mode) begin
      w_shadow_nxt = '0;
    end else if (w_seq_sof) begin
      w_shadow_nxt    = '0;
      w_shadow_nxt[0] = din;
    end else if (w_seq_bit) begin
      w_shadow_nxt[r_slot] = din;
    end
  end

  // Slot counter and FSM: sof moves to slot 1 / COLLECT, the last bit wraps to slot 0 / IDLE.
  always_comb begin
    w_slot_nxt  = r_slot;
    w_state_nxt = r_state;
    if (!sel_mode) begin
      w_slot_nxt  = '0;
      w_state_nxt = ST_IDLE;
    end else if (w_seq_sof) begin
      w_slot_nxt  = ONE_SLOT;
      w_state_nxt = ST_COLLECT;
    end else if (w_done) begin
      w_slot_nxt  = '0;
      w_state_nxt = ST_IDLE;
    end else if (w_seq_bit) begin
      w_slot_nxt  = r_slot + ONE_SLOT;
    end
  end

  // Output bus: one addressed bit per valid cycle, or the whole frame on completion.
  always_comb begin
    w_y_nxt = r_y;
    if (!sel_mode) begin
      if (din_valid) begin
        w_y_nxt[sel] = din;
      end
    end else if (w_done) begin
      w_y_nxt = w_frame_dat;
    end
  end

  // Collector state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_slot   <= '0;
      r_shadow <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_slot   <= w_slot_nxt;
      r_shadow <= w_shadow_nxt;
    end
  end

  // Output registers; the two pulses default low every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_y           <= '0;
      r_frame       <= '0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_y           <= w_y_nxt;
      r_frame_valid <= w_done;
      r_frame_err   <= w_restart;
      if (w_done) begin
        r_frame <= w_frame_dat;
      end
    end
  end

  assign Y           = r_y;
  assign frame       = r_frame;
  assign frame_valid = r_frame_valid;
  assign slot        = r_slot;
  assign frame_err   = r_frame_err;

endmodule
